// File: rtl/input_conditioner.sv
// input_conditioner - synchronise, debounce and edge-detect the six game buttons,
// then turn them into a committed/pending snake heading, a pause level and a restart pulse.
module input_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_pause,
  input  logic       i_restart,
  input  logic       i_step,
  output logic [1:0] o_dir,
  output logic [1:0] o_dir_next,
  output logic       o_pause,
  output logic       o_restart
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam int B_UP      = 0;
  localparam int B_DOWN    = 1;
  localparam int B_LEFT    = 2;
  localparam int B_RIGHT   = 3;
  localparam int B_PAUSE   = 4;
  localparam int B_RESTART = 5;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  logic [5:0]    raw;
  logic [5:0]    sync_q [SYNC_STAGES];
  logic [5:0]    synced;
  logic [5:0]    db_q, db_d;
  logic [5:0]    db_dly_q;
  logic [CW-1:0] cnt_q [6];
  logic [CW-1:0] cnt_d [6];
  logic [5:0]    press;

  logic [1:0] dir_q, dir_d;
  logic [1:0] dir_next_q, dir_next_d;
  logic       pause_q, pause_d;
  logic       restart_q, restart_d;
  logic [1:0] win_dir;
  logic       any_dir;
  logic       accept;

  assign raw    = {i_restart, i_pause, i_right, i_left, i_down, i_up};
  assign synced = sync_q[SYNC_STAGES-1];
  assign press  = db_q & ~db_dly_q;

  always_comb begin
    for (int b = 0; b < 6; b++) begin
      db_d[b]  = db_q[b];
      cnt_d[b] = cnt_q[b];
      if (synced[b] != db_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          db_d[b]  = synced[b];
          cnt_d[b] = '0;
        end else if (cnt_q[b] != CNT_MAX) begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end else begin
        cnt_d[b] = '0;
      end
    end
  end

  always_comb begin
    win_dir = DIR_LEFT;
    if (press[B_UP])         win_dir = DIR_UP;
    else if (press[B_RIGHT]) win_dir = DIR_RIGHT;
    else if (press[B_DOWN])  win_dir = DIR_DOWN;
    any_dir = press[B_UP] | press[B_RIGHT] | press[B_DOWN] | press[B_LEFT];
    // Reversal is judged against the committed heading, not the pending one.
    accept  = any_dir && (win_dir != (dir_q ^ 2'b10));

    dir_next_d = accept ? win_dir : dir_next_q;
    dir_d      = i_step ? dir_next_q : dir_q;
    pause_d    = press[B_PAUSE] ? ~pause_q : pause_q;
    restart_d  = press[B_RESTART];

    if (restart_q) begin
      pause_d    = 1'b0;
      dir_d      = DIR_RIGHT;
      dir_next_d = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int b = 0; b < 6; b++) cnt_q[b] <= '0;
      db_q       <= '0;
      db_dly_q   <= '0;
      dir_q      <= DIR_RIGHT;
      dir_next_q <= DIR_RIGHT;
      pause_q    <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int b = 0; b < 6; b++) cnt_q[b] <= cnt_d[b];
      db_q       <= db_d;
      db_dly_q   <= db_q;
      dir_q      <= dir_d;
      dir_next_q <= dir_next_d;
      pause_q    <= pause_d;
      restart_q  <= restart_d;
    end
  end

  assign o_dir      = dir_q;
  assign o_dir_next = dir_next_q;
  assign o_pause    = pause_q;
  assign o_restart  = restart_q;

endmodule
